strike_loader: RTL and testbench
================================

STRIKE_LOADER -- requirements
Module: strike_loader

Interface
REQ-001 Parameter AW, default 6: instruction-memory address width; the memory holds 2^AW words.
REQ-002 Parameter DW, default 8: instruction word width and byte-stream width.
REQ-003 Port clock, input, 1: single clock; all state is updated on the rising edge.
REQ-004 Port reset_ini, input, 1: asynchronous, active-low reset; assertion clears all state immediately.
REQ-005 Port in_data, input, DW: incoming program byte.
REQ-006 Port in_valid, input, 1: in_data is valid this cycle.
REQ-007 Port in_ready, output, 1: the loader accepts in_data this cycle.
REQ-008 Port reload, input, 1: single-cycle request to restart loading.
REQ-009 Port cpu_addr, input, AW: CPU fetch address.
REQ-010 Port cpu_data, output, DW: fetched word, registered.
REQ-011 Port cpu_rstn, output, 1: active-low reset for the CPU; high only while a verified program is running.
REQ-012 Port loaded, output, 1: a program was received and its checksum matched.
REQ-013 Port error, output, 1: the last load failed (bad length or bad checksum).

Function
REQ-014 A byte shall be transferred only on a rising edge where in_valid=1 and in_ready=1; in_ready shall not depend combinationally on in_valid.
REQ-015 The FSM shall have exactly these states: LEN, DATA, CHECK, RUN, FAIL; it shall enter LEN on reset.
REQ-016 In state LEN, in_ready shall be 1, and the accepted byte is the length header.
REQ-017 Length header, bits [7:AW] nonzero -> FAIL.
REQ-018 Length header, bits [AW-1:0]=0 -> length = 2^AW words (full memory).
REQ-019 Length header, any other valid value -> length = that value.
REQ-020 On leaving LEN for DATA, the word counter shall clear to 0 and the checksum accumulator shall clear to 0.
REQ-021 In state DATA, in_ready shall be 1, and each accepted byte shall be written to memory[counter].
REQ-022 In state DATA, each accepted byte shall be added to the accumulator, which wraps mod 2^DW.
REQ-023 In state DATA, the counter shall increment by 1 per accepted byte; after the length-th byte, the state shall be CHECK.
REQ-024 The counter shall be AW+1 bits wide so that a full-memory load terminates correctly without wrap ambiguity.
REQ-025 In state CHECK, in_ready shall be 1; accepted byte equal to the accumulator -> RUN, otherwise -> FAIL.
REQ-026 In states RUN and FAIL, in_ready shall be 0, and the FSM shall stay in its state until reload=1.
REQ-027 On reload=1 in state RUN or FAIL, the next state shall be LEN, and loaded and error shall clear on that edge.
REQ-028 reload shall be ignored in states LEN, DATA and CHECK.
REQ-029 cpu_rstn shall be 1 if and only if the state is RUN; it shall be a registered output, so it falls on the same edge that leaves RUN.
REQ-030 loaded shall be 1 in RUN only; error shall be 1 in FAIL only; both shall be registered outputs.
REQ-031 Memory contents shall not be reset; words beyond the loaded length shall keep their previous values.
REQ-032 On a FAIL, words already written shall remain written; they are overwritten by the next successful load.
REQ-033 cpu_data shall equal memory[cpu_addr] sampled one clock earlier (synchronous read, 1-cycle latency) in every state.
REQ-034 A write and a read to the same address in the same cycle shall return the old word (read-before-write).
REQ-035 in_valid held high with in_ready low shall have no effect; the byte is not consumed.

Reset
REQ-036 Asserting reset_ini (low) shall immediately force state=LEN, counter=0, accumulator=0, in_ready=1, cpu_rstn=0, loaded=0, error=0 and cpu_data=0.
REQ-037 Reset asserted mid-load shall abort the load; the next byte accepted after deassertion shall be treated as a length header.
REQ-038 Deassertion of reset_ini shall take effect on the next rising edge; no other synchronisation is required.

Verification
REQ-039 Stream 03,11,22,33,66 -> memory[0..2]=11,22,33; RUN; cpu_rstn=1; loaded=1; cpu_addr=1 returns 22 one cycle later.
REQ-040 Stream 02,10,20,31 (expected checksum 30) -> FAIL; error=1; cpu_rstn=0; in_ready=0; then reload pulse -> LEN, error=0.
REQ-041 Header 00 followed by 64 bytes 01 and checksum 40 -> RUN after exactly 66 accepted bytes; memory[63]=01.
REQ-042 Header 45 (bits 7:6 nonzero) -> FAIL immediately; no memory write.
REQ-043 In RUN, toggling in_valid for 10 cycles -> no byte accepted, state unchanged; reload with in_valid=1 on the same cycle -> LEN; that byte is not accepted.
REQ-044 reset_ini pulsed low after 2 data bytes of a 5-byte load -> outputs return to reset values asynchronously; a fresh 01,AA,AA stream -> RUN.

Source files
------------

// File: rtl/strike_loader.sv
// Program loader: receives a length-prefixed, checksummed byte stream into
// instruction memory and releases the CPU from reset once the checksum matches.
module strike_loader #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_ini,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          reload,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_rstn,
  output logic          loaded,
  output logic          error
);

  typedef enum logic [2:0] {LEN, DATA, CHECK, RUN, FAIL} state_t;

  state_t        state, state_next;
  logic [AW:0]   count, length;
  logic [AW:0]   count_inc;
  logic [AW:0]   hdr_len;
  logic          hdr_bad;
  logic          take;
  logic [DW-1:0] sum;
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock or negedge reset_ini) begin
    if (!reset_ini) state <= LEN;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    hdr_bad    = |in_data[DW-1:AW];
    hdr_len    = {1'b0, in_data[AW-1:0]};
    // A zero length field encodes a full-memory load.
    if (in_data[AW-1:0] == '0) hdr_len = {1'b1, {AW{1'b0}}};
    count_inc  = count + (AW+1)'(1);
    case (state)
      LEN:   in_ready = 1'b1;
      DATA:  in_ready = 1'b1;
      CHECK: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    take = in_valid && in_ready;
    case (state)
      LEN:   if (take) state_next = hdr_bad ? FAIL : DATA;
      DATA:  if (take && count_inc == length) state_next = CHECK;
      CHECK: if (take) state_next = (in_data == sum) ? RUN : FAIL;
      RUN:   if (reload) state_next = LEN;
      FAIL:  if (reload) state_next = LEN;
      default: state_next = LEN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_ini) begin
    if (!reset_ini) begin
      count    <= '0;
      length   <= '0;
      sum      <= '0;
      cpu_rstn <= 1'b0;
      loaded   <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (state == LEN && take) begin
        count  <= '0;
        sum    <= '0;
        length <= hdr_len;
      end else if (state == DATA && take) begin
        count <= count_inc;
        sum   <= sum + in_data;
      end
      // Flags track the state being entered so they change on the same edge.
      cpu_rstn <= (state_next == RUN);
      loaded   <= (state_next == RUN);
      error    <= (state_next == FAIL);
    end
  end

  always_ff @(posedge clock) begin
    if (state == DATA && take) mem[count[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clock or negedge reset_ini) begin
    if (!reset_ini) cpu_data <= '0;
    else            cpu_data <= mem[cpu_addr];
  end

endmodule

// File: tb/tb_strike_loader.sv
// Randomized bench for strike_loader, checked against a whole-stream reference model.
module tb_strike_loader;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int WORDS = 2**AW;

  typedef logic [7:0] byte_q_t[$];

  logic          clock = 1'b0;
  logic          reset_ini = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data;
  logic          cpu_rstn, loaded, error;

  strike_loader #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_ini(reset_ini), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rstn(cpu_rstn), .loaded(loaded), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [7:0] mmem [WORDS];
  bit         mknown [WORDS];

  always @(posedge clock) if (reset_ini && in_valid && in_ready) accepted++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-stream prediction: verdict, bytes consumed, and resulting memory image.
  function automatic void model_load(input byte_q_t s, output bit run, output int nacc);
    int h, n;
    logic [7:0] total;
    h = int'(s[0]);
    if (h >= WORDS) begin
      run = 0; nacc = 1; return;
    end
    n = (h == 0) ? WORDS : h;
    total = 8'h00;
    for (int i = 0; i < n; i++) begin
      mmem[i] = s[i+1];
      mknown[i] = 1'b1;
      total = total + s[i+1];
    end
    run = (s[n+1] == total);
    nacc = n + 2;
  endfunction

  task automatic push(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input string tag, input byte_q_t s, input bit gaps);
    bit run;
    int nacc, a0;
    a0 = accepted;
    model_load(s, run, nacc);
    foreach (s[i]) push(s[i], gaps ? int'($urandom_range(0, 2)) : 0);
    check({tag, "_acc"}, accepted - a0, nacc);
    check({tag, "_loaded"}, loaded, run);
    check({tag, "_error"}, error, !run);
    check({tag, "_cpu_rstn"}, cpu_rstn, run);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < WORDS; a++) begin
      if (mknown[a]) begin
        cpu_addr = AW'(a);
        @(negedge clock);
        check(tag, {cpu_addr, cpu_data}, {AW'(a), mmem[a]});
      end
    end
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    check({tag, "_rl_ready"}, in_ready, 1);
    check({tag, "_rl_flags"}, {cpu_rstn, loaded, error}, 3'b000);
  endtask

  initial begin
    byte_q_t q;
    int a0, n;
    logic [7:0] b1, b2, total;
    for (int i = 0; i < WORDS; i++) mknown[i] = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", {cpu_rstn, loaded, error}, 3'b000);
    check("rst_cpu_data", cpu_data, 0);
    reset_ini = 1'b1;
    @(negedge clock);

    q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_stream("good3", q, 0);
    cpu_addr = 6'd1;
    @(negedge clock);
    check("good3_rd1", cpu_data, 8'h22);
    readback("good3_mem");
    do_reload("good3");

    q = '{8'h02, 8'h10, 8'h20, 8'h31};
    run_stream("badsum", q, 0);
    do_reload("badsum");

    q = {};
    q.push_back(8'h00);
    repeat (WORDS) q.push_back(8'h01);
    q.push_back(8'h40);
    run_stream("full", q, 0);
    cpu_addr = 6'd63;
    @(negedge clock);
    check("full_rd63", cpu_data, 8'h01);
    readback("full_mem");

    a0 = accepted;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_data = 8'($urandom);
      @(negedge clock);
    end
    check("run_hold_acc", accepted - a0, 0);
    check("run_hold_flags", {cpu_rstn, loaded, error}, 3'b110);
    in_valid = 1'b1;
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    in_valid = 1'b0;
    check("reload_valid_acc", accepted - a0, 0);
    check("reload_valid_ready", in_ready, 1);
    check("reload_valid_flags", {cpu_rstn, loaded, error}, 3'b000);

    q = '{8'h45};
    run_stream("badhdr", q, 0);
    readback("badhdr_mem");
    do_reload("badhdr");

    b1 = 8'($urandom_range(1, 255));
    b2 = 8'($urandom_range(1, 255));
    push(8'h05, 0);
    push(b1, 0);
    push(b2, 0);
    mmem[0] = b1; mknown[0] = 1'b1;
    mmem[1] = b2; mknown[1] = 1'b1;
    cpu_addr = 6'd1;
    @(negedge clock);
    #2 reset_ini = 1'b0;
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_flags", {cpu_rstn, loaded, error}, 3'b000);
    check("async_cpu_data", cpu_data, 0);
    @(negedge clock);
    reset_ini = 1'b1;
    q = '{8'h01, 8'hAA, 8'hAA};
    run_stream("post_rst", q, 0);
    readback("post_rst_mem");
    do_reload("post_rst");

    for (int it = 0; it < 25; it++) begin
      q = {};
      if ($urandom_range(0, 7) == 0) begin
        q.push_back(8'($urandom_range(WORDS, 255)));
      end else begin
        n = int'($urandom_range(1, WORDS));
        q.push_back(8'(n % WORDS));
        total = 8'h00;
        for (int i = 0; i < n; i++) begin
          b1 = 8'($urandom);
          q.push_back(b1);
          total = total + b1;
        end
        if ($urandom_range(0, 3) == 0) total = total ^ 8'($urandom_range(1, 255));
        q.push_back(total);
      end
      run_stream("rand", q, 1);
      readback("rand_mem");
      do_reload("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
